// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS core: opcodes, functs, CP0 register
// numbers, fixed PCs and exception codes.
package mips_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] PRID_VALUE = 32'h4D49_5053;

   localparam int unsigned IM_WORDS = 4096;
   localparam int unsigned DM_WORDS = 4096;

   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00,
      OP_J       = 6'h02,
      OP_JAL     = 6'h03,
      OP_BEQ     = 6'h04,
      OP_BNE     = 6'h05,
      OP_ADDIU   = 6'h09,
      OP_ORI     = 6'h0D,
      OP_LUI     = 6'h0F,
      OP_COP0    = 6'h10,
      OP_LW      = 6'h23,
      OP_SW      = 6'h2B
   } opcode_e;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00,
      FN_JR   = 6'h08,
      FN_ERET = 6'h18,
      FN_ADDU = 6'h21,
      FN_SUBU = 6'h23,
      FN_AND  = 6'h24,
      FN_OR   = 6'h25,
      FN_SLT  = 6'h2A
   } funct_e;

   // rs-field selectors inside the COP0 opcode space
   localparam logic [4:0] CO_MF = 5'd0;
   localparam logic [4:0] CO_MT = 5'd4;

   typedef enum logic [4:0] {
      CP0_SR    = 5'd12,
      CP0_CAUSE = 5'd13,
      CP0_EPC   = 5'd14,
      CP0_PRID  = 5'd15
   } cp0_reg_e;

   localparam logic [4:0] EXC_INT = 5'd0;

endpackage

// File: rtl/mips_core_cp0.sv
// Coprocessor 0: status/cause/EPC registers, mfc0 read mux and interrupt request
// generation for the single external interrupt line (IP[2]/IM[2], bit 10).
import mips_pkg::*;

module cp0 (
   input  logic        clk,
   input  logic        reset,
   input  logic        interrupt,
   input  logic [31:0] pc,
   input  logic        mtc0_en,
   input  logic [4:0]  reg_num,
   input  logic [31:0] wr_data,
   input  logic        exc_take,
   input  logic        eret,
   output logic [31:0] rd_data,
   output logic [31:0] epc,
   output logic        irq_req
);

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_ip2;
   logic [4:0]  cause_exc;
   logic [31:0] sr;
   logic [31:0] cause;

   assign sr      = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
   assign cause   = {16'h0, 5'h0, cause_ip2, 3'h0, cause_exc, 2'h0};
   assign irq_req = interrupt & sr_im[0] & sr_ie & ~sr_exl;

   always_comb begin
      rd_data = '0;
      case (cp0_reg_e'(reg_num))
         CP0_SR:    rd_data = sr;
         CP0_CAUSE: rd_data = cause;
         CP0_EPC:   rd_data = epc;
         CP0_PRID:  rd_data = PRID_VALUE;
         default:   rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_im     <= '0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_ip2 <= 1'b0;
         cause_exc <= '0;
         epc       <= '0;
      end else begin
         cause_ip2 <= interrupt;
         // exception entry wins over any mtc0/eret in the same cycle
         if (exc_take) begin
            epc       <= pc;
            sr_exl    <= 1'b1;
            cause_exc <= EXC_INT;
         end else if (mtc0_en) begin
            case (cp0_reg_e'(reg_num))
               CP0_SR: begin
                  sr_im  <= wr_data[15:10];
                  sr_exl <= wr_data[1];
                  sr_ie  <= wr_data[0];
               end
               CP0_CAUSE: cause_exc <= wr_data[6:2];
               CP0_EPC:   epc       <= wr_data;
               default: ;
            endcase
         end else if (eret) begin
            sr_exl <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS-I subset core: PC, instruction/data memories, register file,
// decode and ALU; interrupt handling lives in the cp0 sub-module.
import mips_pkg::*;

module mips_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        interrupt,
   output logic [31:0] addr
);

   logic [31:0] imem [IM_WORDS];
   logic [31:0] dmem [DM_WORDS];
   logic [31:0] gpr  [32];

   logic [31:0] pc, pc_plus4, next_pc, instr;
   logic [11:0] im_index, dm_index;
   opcode_e     op;
   funct_e      fn;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] sext_imm, zext_imm, rs_val, rt_val, mem_addr;
   logic        reg_we, mem_we, mtc0_en, eret, irq;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata, cp0_rdata, epc;

   assign addr     = pc;
   assign pc_plus4 = pc + 32'd4;
   assign im_index = 12'((pc - RESET_PC) >> 2);
   assign instr    = imem[im_index];

   assign op       = opcode_e'(instr[31:26]);
   assign fn       = funct_e'(instr[5:0]);
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign shamt    = instr[10:6];
   assign sext_imm = {{16{instr[15]}}, instr[15:0]};
   assign zext_imm = {16'h0, instr[15:0]};

   assign rs_val   = (rs == '0) ? '0 : gpr[rs];
   assign rt_val   = (rt == '0) ? '0 : gpr[rt];
   assign mem_addr = rs_val + sext_imm;
   assign dm_index = 12'(mem_addr >> 2);

   always_comb begin
      reg_we    = 1'b0;
      reg_waddr = rd;
      reg_wdata = '0;
      mem_we    = 1'b0;
      mtc0_en   = 1'b0;
      eret      = 1'b0;
      next_pc   = pc_plus4;
      case (op)
         OP_SPECIAL: begin
            case (fn)
               FN_ADDU: begin reg_we = 1'b1; reg_wdata = rs_val + rt_val; end
               FN_SUBU: begin reg_we = 1'b1; reg_wdata = rs_val - rt_val; end
               FN_AND:  begin reg_we = 1'b1; reg_wdata = rs_val & rt_val; end
               FN_OR:   begin reg_we = 1'b1; reg_wdata = rs_val | rt_val; end
               FN_SLT:  begin
                  reg_we    = 1'b1;
                  reg_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
               end
               FN_SLL:  begin reg_we = 1'b1; reg_wdata = rt_val << shamt; end
               FN_JR:   next_pc = rs_val;
               default: ;
            endcase
         end
         OP_ORI:   begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = rs_val | zext_imm; end
         OP_LUI:   begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = {instr[15:0], 16'h0}; end
         OP_ADDIU: begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = mem_addr; end
         OP_LW:    begin reg_we = 1'b1; reg_waddr = rt; reg_wdata = dmem[dm_index]; end
         OP_SW:    mem_we = 1'b1;
         OP_BEQ:   if (rs_val == rt_val) next_pc = pc_plus4 + (sext_imm << 2);
         OP_BNE:   if (rs_val != rt_val) next_pc = pc_plus4 + (sext_imm << 2);
         OP_J:     next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
         OP_JAL:   begin
            reg_we    = 1'b1;
            reg_waddr = 5'd31;
            reg_wdata = pc_plus4;
            next_pc   = {pc_plus4[31:28], instr[25:0], 2'b00};
         end
         OP_COP0: begin
            if (rs == CO_MF) begin
               reg_we    = 1'b1;
               reg_waddr = rt;
               reg_wdata = cp0_rdata;
            end else if (rs == CO_MT) begin
               mtc0_en = 1'b1;
            end else if (instr[25] && fn == FN_ERET) begin
               eret    = 1'b1;
               next_pc = epc;
            end
         end
         default: ;
      endcase
      // a taken interrupt squashes every side effect of the instruction at addr
      if (irq) begin
         reg_we  = 1'b0;
         mem_we  = 1'b0;
         mtc0_en = 1'b0;
         eret    = 1'b0;
         next_pc = HANDLER_PC;
      end
   end

   cp0 u_cp0 (
      .clk      (clk),
      .reset    (reset),
      .interrupt(interrupt),
      .pc       (pc),
      .mtc0_en  (mtc0_en),
      .reg_num  (rd),
      .wr_data  (rt_val),
      .exc_take (irq),
      .eret     (eret),
      .rd_data  (cp0_rdata),
      .epc      (epc),
      .irq_req  (irq)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
         for (int unsigned i = 0; i < 32; i++) gpr[i] <= '0;
      end else begin
         pc <= next_pc;
         if (reg_we && reg_waddr != '0) gpr[reg_waddr] <= reg_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DM_WORDS; i++) dmem[i] <= '0;
      end else if (mem_we) begin
         dmem[dm_index] <= rt_val;
      end
   end

endmodule

// File: tb/tb_mips_core.sv
// Self-checking bench for mips_core: directed program with a random ALU/memory
// block, checked step by step against an instruction-level reference model.
module tb_mips_core;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        interrupt = 1'b0;
   logic [31:0] addr;

   int checks = 0;
   int failures = 0;

   mips_core dut (.clk(clk), .reset(reset), .interrupt(interrupt), .addr(addr));

   always #5 clk = ~clk;

   // reference architectural state
   logic [31:0] prog  [4096];
   logic [31:0] m_gpr [32];
   logic [31:0] m_dm  [4096];
   logic [31:0] m_pc, m_sr, m_cause, m_epc;

   function automatic logic [31:0] enc_r(int s, int t, int d, int sh, int f);
      return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(f)};
   endfunction
   function automatic logic [31:0] enc_i(int o, int s, int t, int imm);
      return {6'(o), 5'(s), 5'(t), 16'(imm)};
   endfunction
   function automatic logic [31:0] enc_j(int o, logic [31:0] target);
      return {6'(o), target[27:2]};
   endfunction
   function automatic logic [31:0] enc_mtc0(int t, int d);
      return {6'h10, 5'd4, 5'(t), 5'(d), 11'd0};
   endfunction
   function automatic logic [31:0] enc_mfc0(int t, int d);
      return {6'h10, 5'd0, 5'(t), 5'(d), 11'd0};
   endfunction

   task automatic place(input logic [31:0] a, input logic [31:0] w);
      prog[(a - 32'h3000) >> 2] = w;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h3000; m_sr = 0; m_cause = 0; m_epc = 0;
      for (int i = 0; i < 32; i++) m_gpr[i] = 0;
      for (int i = 0; i < 4096; i++) m_dm[i] = 0;
   endtask

   task automatic wr_gpr(input int r, input logic [31:0] v);
      if (r != 0) m_gpr[r] = v;
   endtask

   // One architectural step: either take the interrupt or execute one instruction.
   task automatic model_step(input bit irq);
      logic [31:0] ins, a, b, simm, npc, cause_pre, cp0v;
      int op, fn, rs, rt, rd, sh, idx;
      bit take;
      cause_pre = m_cause;
      take = irq && m_sr[10] && m_sr[0] && !m_sr[1];
      if (take) begin
         m_epc = m_pc;
         m_sr[1] = 1'b1;
         m_cause[6:2] = 5'd0;
         m_pc = 32'h4180;
      end else begin
         idx = int'((m_pc - 32'h3000) >> 2);
         ins = (idx >= 0 && idx < 4096) ? prog[idx] : 32'h0;
         op = int'(ins[31:26]); fn = int'(ins[5:0]);
         rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
         a = m_gpr[rs]; b = m_gpr[rt];
         simm = {{16{ins[15]}}, ins[15:0]};
         npc = m_pc + 4;
         case (op)
            'h00: case (fn)
               'h21: wr_gpr(rd, a + b);
               'h23: wr_gpr(rd, a - b);
               'h24: wr_gpr(rd, a & b);
               'h25: wr_gpr(rd, a | b);
               'h2A: wr_gpr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
               'h00: wr_gpr(rd, b << sh);
               'h08: npc = a;
               default: ;
            endcase
            'h0D: wr_gpr(rt, a | {16'h0, ins[15:0]});
            'h0F: wr_gpr(rt, {ins[15:0], 16'h0});
            'h09: wr_gpr(rt, a + simm);
            'h23: wr_gpr(rt, m_dm[((a + simm) >> 2) % 4096]);
            'h2B: m_dm[((a + simm) >> 2) % 4096] = b;
            'h04: if (a == b) npc = m_pc + 4 + simm * 4;
            'h05: if (a != b) npc = m_pc + 4 + simm * 4;
            'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            'h03: begin wr_gpr(31, m_pc + 4); npc = {npc[31:28], ins[25:0], 2'b00}; end
            'h10: begin
               if (rs == 0) begin
                  case (rd)
                     12: cp0v = m_sr;
                     13: cp0v = cause_pre;
                     14: cp0v = m_epc;
                     15: cp0v = 32'h4D495053;
                     default: cp0v = 0;
                  endcase
                  wr_gpr(rt, cp0v);
               end else if (rs == 4) begin
                  if (rd == 12) m_sr = b & 32'h0000_FC03;
                  else if (rd == 13) m_cause = (m_cause & ~32'h7C) | (b & 32'h7C);
                  else if (rd == 14) m_epc = b;
               end else if (ins[25] && fn == 'h18) begin
                  npc = m_epc;
                  m_sr[1] = 1'b0;
               end
            end
            default: ;
         endcase
         m_pc = npc;
      end
      m_cause[10] = irq;
   endtask

   task automatic step(input bit irq);
      interrupt = irq;
      model_step(irq);
      @(posedge clk);
      #1;
      check("addr", addr, m_pc);
   endtask

   task automatic run_until(input logic [31:0] target);
      int n = 0;
      while (m_pc != target && n < 300) begin
         step(1'b0);
         n++;
      end
      check("reach_target", addr, target);
   endtask

   initial begin
      int kind, d, s, t;
      logic [31:0] a;

      for (int i = 0; i < 4096; i++) prog[i] = 32'h0;
      // directed basics
      place(32'h300C, enc_i('h0D, 0, 1, 'h1234));
      place(32'h3010, enc_i('h0F, 0, 2, 'hABCD));
      place(32'h3014, enc_r(1, 2, 3, 0, 'h21));
      place(32'h3018, enc_i('h2B, 0, 3, 0));
      place(32'h301C, enc_i('h23, 0, 4, 0));
      place(32'h3020, enc_i('h04, 4, 3, 1));
      place(32'h3024, enc_i('h0D, 0, 5, 'hDEAD));
      place(32'h3028, enc_i('h0D, 0, 10, 'h0401));
      place(32'h302C, enc_mtc0(10, 12));
      place(32'h3030, enc_j('h03, 32'h3100));
      place(32'h3034, enc_j('h02, 32'h3200));
      // random ALU/memory subroutine on $0..$9
      a = 32'h3100;
      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 10);
         d = $urandom_range(0, 9); s = $urandom_range(0, 9); t = $urandom_range(0, 9);
         case (kind)
            0: place(a, enc_r(s, t, d, 0, 'h21));
            1: place(a, enc_r(s, t, d, 0, 'h23));
            2: place(a, enc_r(s, t, d, 0, 'h24));
            3: place(a, enc_r(s, t, d, 0, 'h25));
            4: place(a, enc_r(s, t, d, 0, 'h2A));
            5: place(a, enc_r(0, t, d, $urandom_range(0, 31), 'h00));
            6: place(a, enc_i('h0D, s, d, $urandom_range(0, 65535)));
            7: place(a, enc_i('h0F, 0, d, $urandom_range(0, 65535)));
            8: place(a, enc_i('h09, s, d, $urandom_range(0, 65535)));
            9: place(a, enc_i('h2B, 0, t, 4 * $urandom_range(0, 63)));
            default: place(a, enc_i('h23, 0, d, 4 * $urandom_range(0, 63)));
         endcase
         a += 4;
      end
      place(a, enc_r(31, 0, 0, 0, 'h08));
      place(32'h3200, enc_i('h05, 0, 0, 5));
      place(32'h3204, enc_mfc0(25, 15));
      place(32'h3208, enc_i('h05, 31, 0, 'h19));
      place(32'h3278, enc_i('h09, 20, 20, 1));
      place(32'h327C, enc_mtc0(0, 12));
      place(32'h3288, enc_mfc0(24, 13));
      place(32'h328C, enc_i('h0D, 0, 11, 'h3400));
      place(32'h3290, enc_mtc0(11, 14));
      place(32'h3294, 32'h4200_0018);
      place(32'h3400, enc_i('h0D, 0, 10, 'h0401));
      place(32'h3404, enc_mtc0(10, 12));
      // interrupt handler
      place(32'h4180, enc_mfc0(21, 13));
      place(32'h4184, enc_mfc0(22, 14));
      place(32'h4188, enc_mfc0(23, 12));
      place(32'h4198, 32'h4200_0018);
      for (int i = 0; i < 4096; i++) dut.imem[i] = prog[i];

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_addr", addr, 32'h3000);
      check("reset_sr", dut.u_cp0.sr, 32'h0);
      #2 reset = 1'b1;

      repeat (3) step(1'b0);
      check("nop3_addr", addr, 32'h300C);
      repeat (6) step(1'b0);
      check("beq_target", addr, 32'h3028);
      check("lw_result", dut.gpr[4], 32'hABCD1234);
      check("beq_skipped", dut.gpr[5], 32'h0);

      run_until(32'h3270);
      for (int i = 1; i < 32; i++) check($sformatf("gpr%0d", i), dut.gpr[i], m_gpr[i]);
      for (int i = 0; i < 64; i++) check($sformatf("dm%0d", i), dut.dmem[i], m_dm[i]);

      run_until(32'h3278);
      step(1'b1);
      check("vector_addr", addr, 32'h4180);
      check("vector_epc", dut.u_cp0.epc, 32'h3278);
      check("vector_exl", {31'h0, dut.u_cp0.sr[1]}, 32'h1);
      check("vector_ip2", {31'h0, dut.u_cp0.cause[10]}, 32'h1);
      check("squashed", dut.gpr[20], 32'h0);
      repeat (6) step(1'b1);
      check("held_in_handler", addr, 32'h4198);
      step(1'b0);
      check("eret_addr", addr, 32'h3278);
      check("eret_exl", {31'h0, dut.u_cp0.sr[1]}, 32'h0);
      step(1'b0);
      check("replay_once", dut.gpr[20], 32'h1);
      check("mfc0_cause", dut.gpr[21], 32'h0000_0400);
      check("mfc0_epc", dut.gpr[22], 32'h3278);
      check("mfc0_sr", dut.gpr[23], 32'h0000_0403);

      step(1'b0);
      repeat (3) step(1'b1);
      check("masked_no_vector", addr, 32'h328C);
      check("masked_ip2", dut.gpr[24], 32'h0000_0400);
      run_until(32'h3400);

      step(1'b1);
      step(1'b1);
      check("ie_next_edge", addr, 32'h3408);
      step(1'b1);
      check("late_vector", addr, 32'h4180);
      check("late_epc", dut.u_cp0.epc, 32'h3408);
      step(1'b1);
      check("pre_reset_addr", addr, 32'h4184);
      for (int i = 25; i < 26; i++) check("prid", dut.gpr[i], m_gpr[i]);

      #3 reset = 1'b0;
      interrupt = 1'b0;
      #1;
      model_reset();
      check("async_reset_addr", addr, 32'h3000);
      check("async_reset_sr", dut.u_cp0.sr, 32'h0);
      check("async_reset_epc", dut.u_cp0.epc, 32'h0);
      check("async_reset_gpr", dut.gpr[20], 32'h0);
      check("async_reset_dm", dut.dmem[0], 32'h0);
      @(posedge clk);
      #3 reset = 1'b1;
      repeat (4) step(1'b0);
      check("post_reset_run", addr, 32'h3010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_core.md
# mips_core

Single-cycle MIPS-I subset processor with a coprocessor-0 (CP0) block for one external hardware interrupt. It is the top of the CPU test harness: it fetches from internal instruction memory, executes against an internal register file and data memory, and exports the current PC on `addr`. It vectors to a fixed handler on the interrupt and returns via `eret`.

## Interface
- No parameters. Fixed constants: reset PC 0x0000_3000, handler 0x0000_4180.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. `reset`=0 clears state immediately.
- `interrupt`  in  1  external level interrupt, sampled on the rising edge and mapped to Cause.IP[2].
- `addr`  out  32  PC of the instruction being executed this cycle, i.e. the macroscopic PC.

## Operation
- Instruction memory: 4096 words covering 0x3000–0x6FFF, loaded from `code.txt` by `$readmemh`. Index is (PC−0x3000)[13:2].
- Data memory: 4096 words covering 0x0000–0x3FFF, word-aligned, cleared at reset.
- Register file: 32×32. $0 always reads 0. Writes to $0 are discarded.
- Supported instructions: addu, subu, and, or, slt, sll, ori, lui, addiu, lw, sw, beq, bne, j, jal, jr, mfc0, mtc0, eret, nop.
  - There are no branch delay slots; the next PC is the target when taken, else PC+4.
  - Any other encoding executes as nop.
- Immediate extension:
  - ori zero-extends.
  - addiu, lw, sw and the branch offset sign-extend.
  - lui loads imm<<16.
  - Arithmetic is modulo 2^32 with no overflow trap.
- CP0 registers (mfc0/mtc0 `rd` field):
  - SR (12): IM[15:10], EXL[1], IE[0].
  - Cause (13): IP[15:10] read-only, ExcCode[6:2].
  - EPC (14).
  - PRId (15): reads 0x4D495053.
  - Unimplemented numbers read 0; writes to them are ignored.
- Interrupt request: IR = `interrupt` & SR.IM[2] & SR.IE & ~SR.EXL, evaluated on pre-edge SR values.
- When IR=1 at an edge:
  - The instruction at `addr` is not executed; there are no register or memory writes.
  - EPC←addr, SR.EXL←1, Cause.ExcCode←0, PC←0x4180.
- Cause.IP[2] is written from `interrupt` every cycle regardless of masking.
- eret: PC←EPC, SR.EXL←0.
- mtc0 to EPC: a following eret uses the new value.

## Timing
- Reset (`reset`=0): PC=0x3000, `addr`=0x3000, GPRs=0, SR=0, Cause=0, EPC=0, DM=0.
- Release on a `reset` high transition; the first instruction executes at the next rising edge.
- One instruction per cycle. `addr` changes only on rising edges (or asynchronously at reset).
- Register writes are visible to the next instruction. Reads within one cycle see pre-edge values.
- Interrupt latency: `interrupt` high before edge N with IR=1 gives `addr`=0x4180 after edge N.
- Simultaneous events:
  - The interrupt has priority over any instruction at `addr`, including eret and mtc0.
  - An mtc0 that enables IE in cycle N affects IR from edge N+1.
- Level `interrupt` held while EXL=1 is ignored. After eret clears EXL, a still-high line retriggers on the next edge.
- Reset asserted mid-handler aborts everything and restores the reset values.

## Structure
- Shared package `mips_pkg` holds:
  - opcode/funct constants
  - CP0 register numbers
  - RESET_PC and HANDLER_PC
  - ExcCode values
- Sub-module `cp0`:
  - SR/Cause/EPC registers, read mux, IR generation
  - inputs: mtc0 write enable/address/data, exception take, eret, `interrupt`, current PC
- Remaining datapath (PC, IM, GPR, ALU, DM, decode) stays in `mips_core`.

## Test plan
- Reset low for 2 cycles, then high → `addr`=0x3000. After 3 nop cycles `addr`=0x300C.
- `ori $1,$0,0x1234`; `lui $2,0xABCD`; `addu $3,$1,$2`; `sw $3,0($0)`; `lw $4,0($0)` → $4=0xABCD1234. A `beq $4,$3` taken moves `addr` to the target.
- Program sets SR=0x0401 via mtc0. Raise `interrupt` when `addr`=0x3278 → next `addr`=0x4180, EPC=0x3278, SR.EXL=1, Cause bit10=1. The instruction at 0x3278 has not executed.
- Handler holds `interrupt` 6 cycles, then executes eret → `addr`=0x3278, EXL=0, and the instruction at 0x3278 executes once.
- SR=0x0000 (IE=0) with `interrupt` high → no vector. Cause bit10 reads 1 via mfc0.
- `reset` pulled low while `addr`=0x4184 → `addr`=0x3000, SR=EPC=0 immediately.
